// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet/flit enums, header field positions and a flit builder.
package noc_pkg;

    localparam int FLIT_W    = 288;
    localparam int PAYLOAD_W = 256;
    localparam int COORD_W   = 4;

    localparam int HDR_TYPE_LSB = 285;
    localparam int HDR_QOS_LSB  = 283;
    localparam int HDR_KIND_LSB = 281;
    localparam int HDR_DX_LSB   = 277;
    localparam int HDR_DY_LSB   = 273;
    localparam int HDR_SX_LSB   = 269;
    localparam int HDR_SY_LSB   = 265;
    localparam int HDR_LEN_LSB  = 260;
    localparam int HDR_ID_LSB   = 256;

    typedef enum logic [2:0] {
        READ_REQ   = 3'd0,
        WRITE_REQ  = 3'd1,
        READ_RESP  = 3'd2,
        WRITE_RESP = 3'd3,
        ATOMIC_REQ = 3'd4,
        MSG        = 3'd5
    } pkt_type_t;

    typedef enum logic [1:0] {
        QOS_LOW  = 2'd0,
        QOS_MED  = 2'd1,
        QOS_HIGH = 2'd2,
        QOS_RT   = 2'd3
    } qos_level_t;

    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_NORTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_SOUTH = 3'd3,
        DIR_WEST  = 3'd4
    } direction_t;

    typedef enum logic [1:0] {
        KIND_BODY   = 2'b00,
        KIND_HEAD   = 2'b01,
        KIND_TAIL   = 2'b10,
        KIND_SINGLE = 2'b11
    } flit_kind_t;

    function automatic logic [FLIT_W-1:0] make_flit(
        input pkt_type_t              t,
        input qos_level_t             q,
        input flit_kind_t             k,
        input logic [COORD_W-1:0]     dx,
        input logic [COORD_W-1:0]     dy,
        input logic [COORD_W-1:0]     sx,
        input logic [COORD_W-1:0]     sy,
        input logic [4:0]             len,
        input logic [3:0]             id,
        input logic [PAYLOAD_W-1:0]   payload
    );
        logic [FLIT_W-1:0] f;
        f = '0;
        f[PAYLOAD_W-1:0]            = payload;
        f[HDR_TYPE_LSB +: 3]        = t;
        f[HDR_QOS_LSB  +: 2]        = q;
        f[HDR_KIND_LSB +: 2]        = k;
        f[HDR_DX_LSB   +: COORD_W]  = dx;
        f[HDR_DY_LSB   +: COORD_W]  = dy;
        f[HDR_SX_LSB   +: COORD_W]  = sx;
        f[HDR_SY_LSB   +: COORD_W]  = sy;
        f[HDR_LEN_LSB  +: 5]        = len;
        f[HDR_ID_LSB   +: 4]        = id;
        return f;
    endfunction

endpackage

// File: rtl/noc_flit_out_reg.sv
// Single-entry valid/ready output register; a new flit may load in the same cycle the old one leaves.
module noc_flit_out_reg
    import noc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [FLIT_W-1:0] i_flit,
    input  logic              i_ready,
    output logic [FLIT_W-1:0] o_flit,
    output logic              o_valid,
    output logic              o_slot_free
);

    logic [FLIT_W-1:0] r_flit;
    logic              r_valid;

    assign o_slot_free = !r_valid || i_ready;
    assign o_flit      = r_flit;
    assign o_valid     = r_valid;

    // Holding register: load when the slot frees, otherwise drop valid after a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit  <= '0;
            r_valid <= 1'b0;
        end else if (i_load && o_slot_free) begin
            r_flit  <= i_flit;
            r_valid <= 1'b1;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_valid;
        end
    end

endmodule

// File: rtl/noc_packetizer.sv
// Local-port injection stage: turns a request plus data beats into header/payload flits,
// dropping packets with out-of-mesh destinations or oversize lengths.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int X_COORD     = 0,
    parameter int Y_COORD     = 0,
    parameter int MESH_SIZE_X = 4,
    parameter int MESH_SIZE_Y = 4,
    parameter int MAX_BEATS   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  pkt_type_t            req_type,
    input  qos_level_t           req_qos,
    input  logic [COORD_W-1:0]   req_dest_x,
    input  logic [COORD_W-1:0]   req_dest_y,
    input  logic [63:0]          req_addr,
    input  logic [4:0]           req_len,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic [PAYLOAD_W-1:0] data_in,
    output logic [FLIT_W-1:0]    flit_out,
    output logic                 flit_valid,
    input  logic                 flit_ready,
    output logic                 busy,
    output logic                 err_dest,
    output logic [31:0]          pkts_sent,
    output logic [15:0]          pkts_dropped
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BODY = 2'd1, ST_DROP = 2'd2} state_t;

    localparam logic [4:0]         MAX_LEN = 5'(MAX_BEATS);
    localparam logic [4:0]         SIZE_X  = 5'(MESH_SIZE_X);
    localparam logic [4:0]         SIZE_Y  = 5'(MESH_SIZE_Y);
    localparam logic [COORD_W-1:0] SRC_X   = COORD_W'(X_COORD);
    localparam logic [COORD_W-1:0] SRC_Y   = COORD_W'(Y_COORD);

    state_t             r_state;
    pkt_type_t          r_type;
    qos_level_t         r_qos;
    logic [COORD_W-1:0] r_dx;
    logic [COORD_W-1:0] r_dy;
    logic [4:0]         r_len;
    logic [3:0]         r_id;
    logic [3:0]         r_pkt_id;
    logic [4:0]         r_remaining;
    logic               r_err;
    logic [31:0]        r_sent;
    logic [15:0]        r_dropped;

    logic              w_slot_free;
    logic              w_req_fire;
    logic              w_data_fire;
    logic              w_dest_ok;
    logic              w_load;
    logic [FLIT_W-1:0] w_flit;
    logic [FLIT_W-1:0] w_out_flit;
    logic              w_out_valid;
    logic              w_last_hs;

    assign w_dest_ok   = ({1'b0, req_dest_x} < SIZE_X) && ({1'b0, req_dest_y} < SIZE_Y)
                         && (req_len <= MAX_LEN);
    assign req_ready   = (r_state == ST_IDLE) && w_slot_free;
    assign data_ready  = (r_state == ST_DROP) || ((r_state == ST_BODY) && w_slot_free);
    assign w_req_fire  = req_valid && req_ready;
    assign w_data_fire = data_valid && data_ready;
    // TAIL (10) and SINGLE (11) both have the upper kind bit set.
    assign w_last_hs   = w_out_valid && flit_ready && w_out_flit[HDR_KIND_LSB + 1];

    assign flit_out     = w_out_flit;
    assign flit_valid   = w_out_valid;
    assign busy         = (r_state != ST_IDLE) || w_out_valid;
    assign err_dest     = r_err;
    assign pkts_sent    = r_sent;
    assign pkts_dropped = r_dropped;

    // Next flit: head/single from the live request, body/tail from the latched header.
    always_comb begin
        w_load = 1'b0;
        w_flit = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_fire && w_dest_ok) begin
                    w_load = 1'b1;
                    w_flit = make_flit(req_type, req_qos,
                                       (req_len == 5'd0) ? KIND_SINGLE : KIND_HEAD,
                                       req_dest_x, req_dest_y, SRC_X, SRC_Y, req_len,
                                       r_pkt_id, {192'd0, req_addr});
                end else begin
                    w_load = 1'b0;
                end
            end
            ST_BODY: begin
                if (w_data_fire) begin
                    w_load = 1'b1;
                    w_flit = make_flit(r_type, r_qos,
                                       (r_remaining == 5'd1) ? KIND_TAIL : KIND_BODY,
                                       r_dx, r_dy, SRC_X, SRC_Y, r_len, r_id, data_in);
                end else begin
                    w_load = 1'b0;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    noc_flit_out_reg u_out_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_flit      (w_flit),
        .i_ready     (flit_ready),
        .o_flit      (w_out_flit),
        .o_valid     (w_out_valid),
        .o_slot_free (w_slot_free)
    );

    // Packet FSM, request latch, packet id and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_type      <= READ_REQ;
            r_qos       <= QOS_LOW;
            r_dx        <= '0;
            r_dy        <= '0;
            r_len       <= 5'd0;
            r_id        <= 4'd0;
            r_pkt_id    <= 4'd0;
            r_remaining <= 5'd0;
            r_err       <= 1'b0;
            r_sent      <= 32'd0;
            r_dropped   <= 16'd0;
        end else begin
            r_err <= 1'b0;
            if (w_last_hs) begin
                r_sent <= r_sent + 32'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_req_fire) begin
                        r_type      <= req_type;
                        r_qos       <= req_qos;
                        r_dx        <= req_dest_x;
                        r_dy        <= req_dest_y;
                        r_len       <= req_len;
                        r_remaining <= req_len;
                        if (w_dest_ok) begin
                            r_id     <= r_pkt_id;
                            r_pkt_id <= r_pkt_id + 4'd1;
                            r_state  <= (req_len == 5'd0) ? ST_IDLE : ST_BODY;
                        end else begin
                            r_err <= 1'b1;
                            if (r_dropped != 16'hFFFF) begin
                                r_dropped <= r_dropped + 16'd1;
                            end
                            r_state <= (req_len == 5'd0) ? ST_IDLE : ST_DROP;
                        end
                    end
                end
                ST_BODY, ST_DROP: begin
                    if (w_data_fire) begin
                        r_remaining <= r_remaining - 5'd1;
                        if (r_remaining == 5'd1) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_noc_packetizer.sv
// Scoreboard bench for noc_packetizer: directed requests push expected flits, a monitor pops on handshake.
module tb_noc_packetizer;
    import noc_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    pkt_type_t    req_type;
    qos_level_t   req_qos;
    logic [3:0]   req_dest_x;
    logic [3:0]   req_dest_y;
    logic [63:0]  req_addr;
    logic [4:0]   req_len;
    logic         data_valid;
    logic         data_ready;
    logic [255:0] data_in;
    logic [287:0] flit_out;
    logic         flit_valid;
    logic         flit_ready;
    logic         busy;
    logic         err_dest;
    logic [31:0]  pkts_sent;
    logic [15:0]  pkts_dropped;

    logic [287:0] exp_q[$];
    int           hs_cyc[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           err_pulses = 0;
    logic [3:0]   exp_id = 4'd0;
    logic         stalled_prev = 1'b0;
    logic [287:0] prev_flit = '0;

    logic [2:0]   cur_t;
    logic [1:0]   cur_q;
    logic [3:0]   cur_dx, cur_dy, cur_id;
    logic [4:0]   cur_len;

    noc_packetizer dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type), .req_qos(req_qos),
        .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_addr(req_addr), .req_len(req_len),
        .data_valid(data_valid), .data_ready(data_ready), .data_in(data_in),
        .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .busy(busy), .err_dest(err_dest), .pkts_sent(pkts_sent), .pkts_dropped(pkts_dropped)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Expected flit as laid out on the wire; this node is (0,0).
    function automatic logic [287:0] exp_flit(input logic [2:0] t, input logic [1:0] q,
            input logic [1:0] k, input logic [3:0] dx, input logic [3:0] dy,
            input logic [4:0] len, input logic [3:0] id, input logic [255:0] pl);
        return {t, q, k, dx, dy, 4'd0, 4'd0, len, id, pl};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: stall stability, handshake scoreboard, err_dest pulse count.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_dest) err_pulses++;
            if (flit_valid && stalled_prev) begin
                checks++;
                if (flit_out !== prev_flit) begin
                    failures++;
                    $display("FAIL stall_stable actual=%h required=%h", flit_out, prev_flit);
                end
            end
            if (flit_valid && flit_ready) begin
                checks++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_flit actual=%h required=none", flit_out);
                end else begin
                    logic [287:0] e;
                    e = exp_q.pop_front();
                    if (flit_out !== e) begin
                        failures++;
                        $display("FAIL flit actual=%h required=%h", flit_out, e);
                    end
                end
            end
            stalled_prev = flit_valid && !flit_ready;
            prev_flit    = flit_out;
        end else begin
            stalled_prev = 1'b0;
        end
    end

    task automatic send_req(input pkt_type_t t, input qos_level_t q, input logic [3:0] dx,
            input logic [3:0] dy, input logic [63:0] addr, input logic [4:0] len, input bit legal);
        int n;
        req_valid = 1'b1; req_type = t; req_qos = q;
        req_dest_x = dx; req_dest_y = dy; req_addr = addr; req_len = len;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready && n < 50);
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL req_timeout actual=0 required=1");
        end else if (legal) begin
            cur_t = t; cur_q = q; cur_dx = dx; cur_dy = dy; cur_len = len; cur_id = exp_id;
            exp_q.push_back(exp_flit(t, q, (len == 5'd0) ? 2'b11 : 2'b01, dx, dy, len, exp_id,
                                     {192'd0, addr}));
            exp_id = exp_id + 4'd1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [1:0] kind, input bit expect_flit);
        int n;
        data_valid = 1'b1; data_in = d;
        n = 0;
        do begin @(negedge clk); n++; end while (!data_ready && n < 50);
        if (!data_ready) begin
            checks++; failures++;
            $display("FAIL beat_timeout actual=0 required=1");
        end else if (expect_flit) begin
            exp_q.push_back(exp_flit(cur_t, cur_q, kind, cur_dx, cur_dy, cur_len, cur_id, d));
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_type = READ_REQ; req_qos = QOS_LOW;
        req_dest_x = 4'd0; req_dest_y = 4'd0; req_addr = 64'd0; req_len = 5'd0;
        data_valid = 1'b0; data_in = '0; flit_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flit_valid", 64'(flit_valid), 64'd0);
        check("rst_flit_out", 64'(|flit_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sent", 64'(pkts_sent), 64'd0);
        check("rst_dropped", 64'(pkts_dropped), 64'd0);
        check("rst_err", 64'(err_dest), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single-flit read
        send_req(READ_REQ, QOS_MED, 4'd2, 4'd1, 64'h1000, 5'd0, 1'b1);
        check("t1_latency_valid", 64'(flit_valid), 64'd1);
        drain();
        check("t1_sent", 64'(pkts_sent), 64'd1);

        // 2: write with a 5-cycle stall on beat B
        send_req(WRITE_REQ, QOS_HIGH, 4'd3, 4'd2, 64'hDEAD_BEEF, 5'd3, 1'b1);
        send_beat({8{32'hAAAA_0001}}, 2'b00, 1'b1);
        send_beat({8{32'hBBBB_0002}}, 2'b00, 1'b1);
        flit_ready = 1'b0; data_valid = 1'b1; data_in = {8{32'hCCCC_0003}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_stall_data_ready", 64'(data_ready), 64'd0);
            check("t2_stall_valid", 64'(flit_valid), 64'd1);
        end
        @(posedge clk); #1;
        flit_ready = 1'b1;
        send_beat({8{32'hCCCC_0003}}, 2'b10, 1'b1);
        drain();
        check("t2_sent", 64'(pkts_sent), 64'd2);

        // 3: out-of-mesh destination, beats swallowed
        err_pulses = 0;
        send_req(WRITE_REQ, QOS_LOW, 4'd4, 4'd0, 64'h55, 5'd2, 1'b0);
        send_beat({8{32'h1111_1111}}, 2'b00, 1'b0);
        send_beat({8{32'h2222_2222}}, 2'b00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("t3_err_pulses", 64'(err_pulses), 64'd1);
        check("t3_dropped", 64'(pkts_dropped), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        send_req(READ_REQ, QOS_RT, 4'd3, 4'd3, 64'h2000, 5'd0, 1'b1);
        drain();
        check("t3_sent", 64'(pkts_sent), 64'd3);

        // 4: three back-to-back len-1 packets, including loopback
        hs_cyc.delete();
        send_req(WRITE_REQ, QOS_LOW, 4'd0, 4'd0, 64'hA0, 5'd1, 1'b1);
        send_beat({8{32'h0000_00A1}}, 2'b10, 1'b1);
        send_req(WRITE_REQ, QOS_LOW, 4'd1, 4'd3, 64'hB0, 5'd1, 1'b1);
        send_beat({8{32'h0000_00B1}}, 2'b10, 1'b1);
        send_req(WRITE_REQ, QOS_LOW, 4'd2, 4'd2, 64'hC0, 5'd1, 1'b1);
        send_beat({8{32'h0000_00C1}}, 2'b10, 1'b1);
        drain();
        check("t4_flit_count", 64'(hs_cyc.size()), 64'd6);
        if (hs_cyc.size() == 6) check("t4_span", 64'(hs_cyc[5] - hs_cyc[0]), 64'd5);
        check("t4_sent", 64'(pkts_sent), 64'd6);

        // 5: reset right after the head of a len-4 packet
        send_req(WRITE_REQ, QOS_MED, 4'd1, 4'd1, 64'hF00, 5'd4, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        data_valid = 1'b1; data_in = {8{32'hBAD0_BAD0}};
        #1;
        check("t5_valid", 64'(flit_valid), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_data_ready", 64'(data_ready), 64'd0);
        check("t5_sent", 64'(pkts_sent), 64'd0);
        exp_q.delete();
        exp_id = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_stray", 64'(flit_valid), 64'd0);
        data_valid = 1'b0;

        // 6: 17 single-flit packets, pkt_id wraps
        for (int i = 0; i < 17; i++) begin
            send_req(READ_REQ, QOS_LOW, 4'(i % 4), 4'((i / 4) % 4), 64'(32'h100 * i), 5'd0, 1'b1);
        end
        drain();
        check("t6_sent", 64'(pkts_sent), 64'd17);
        check("t6_dropped", 64'(pkts_dropped), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
Injection stage on the local port of each mesh router. Accepts one transaction request plus 0..MAX_BEATS 256-bit data beats from the tile. Emits 288-bit flits (header + payload) on a valid/ready link that connects directly to the router's local input (flit_in_local / valid_in_local / ready_out_local). Validates the destination coordinates, drops illegal packets and keeps injection statistics.

Parameters:
X_COORD, 0, this node's mesh X; written into the src_x field
Y_COORD, 0, this node's mesh Y; written into the src_y field
MESH_SIZE_X, 4, mesh width; legal dest_x is 0..MESH_SIZE_X-1 (at most 16)
MESH_SIZE_Y, 4, mesh height; legal dest_y is 0..MESH_SIZE_Y-1 (at most 16)
MAX_BEATS, 16, maximum data beats per packet (at most 31)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when valid && ready
req_type  in  3  pkt_type_t
req_qos  in  2  qos_level_t
req_dest_x  in  4  destination X
req_dest_y  in  4  destination Y
req_addr  in  64  transaction address
req_len  in  5  number of data beats that follow (0..31)
data_valid  in  1  data beat present
data_ready  out  1  beat accepted when valid && ready
data_in  in  256  beat payload
flit_out  out  288  flit to router local input
flit_valid  out  1  flit present
flit_ready  in  1  router accepts flit
busy  out  1  FSM not in IDLE, or flit_valid high
err_dest  out  1  one-cycle pulse when a request is dropped
pkts_sent  out  32  count of packets fully injected
pkts_dropped  out  16  count of packets dropped

Behaviour:
- Reset: all outputs 0; flit_out = 0; state = IDLE; pkt_id = 0; counters = 0. Reset may arrive mid-packet; the partial packet is abandoned and no further flits are emitted.
- Flit header [287:256]:
  - [287:285] type; [284:283] qos; [282:281] kind (BODY=00, HEAD=01, TAIL=10, SINGLE=11)
  - [280:277] dest_x; [276:273] dest_y; [272:269] src_x; [268:265] src_y
  - [264:260] len; [259:256] pkt_id
  - The header is identical on every flit of a packet except for kind.
- Payload [255:0]: head/single flit carries addr in [63:0] and 0 in [255:64]. Body/tail flits carry data_in unchanged.
- Output register: slot_free = !flit_valid || flit_ready. A flit loads only when slot_free. flit_out and flit_valid must hold stable while flit_valid && !flit_ready. flit_valid drops after a handshake if no new flit loads in the same cycle.
- FSM states: IDLE, BODY, DROP.
- IDLE:
  - req_ready = slot_free. Latch all request fields on acceptance.
  - Valid request (dest in range and len <= MAX_BEATS): load the head flit. Next cycle flit_valid = 1, so latency is 1 cycle. pkt_id increments, wrapping 15 -> 0.
  - len = 0: kind = SINGLE, stay in IDLE. Otherwise kind = HEAD, go to BODY with remaining = len.
  - Invalid request: no flit, pkt_id unchanged, err_dest pulses next cycle, pkts_dropped increments (saturates at 0xFFFF). Go to DROP if len > 0, else stay in IDLE.
- BODY: data_ready = slot_free. Each accepted beat loads a flit and decrements remaining. kind = TAIL when remaining = 1, else BODY. Go to IDLE after the tail loads.
- DROP: data_ready = 1 unconditionally. Discard beats and decrement remaining; go to IDLE when remaining reaches 0.
- Outside BODY and DROP, data_ready = 0. Outside IDLE, req_ready = 0.
- pkts_sent increments on the flit_valid && flit_ready handshake of a TAIL or SINGLE flit. It is 32-bit and wraps.
- Throughput: 1 flit/cycle sustained, including head-after-tail back-to-back. A new request may be accepted in the cycle after the tail loads.
- dest equal to own coordinates is legal (loopback).

Decomposition:
- Shared package noc_pkg holds:
  - pkt_type_t, qos_level_t, direction_t (moved out of the router)
  - flit_kind_t
  - header field bit-position localparams
  - FLIT_W = 288, COORD_W = 4
- One natural sub-module: noc_flit_out_reg, the single-entry valid/ready output register.

Test Plan:
1. Node (0,0): READ_REQ, dest (2,1), addr 0x1000, len 0, flit_ready = 1 -> one flit the next cycle, kind SINGLE, [63:0] = 0x1000, pkt_id 0; pkts_sent = 1.
2. WRITE_REQ, len 3, beats A/B/C; hold flit_ready low for 5 cycles on beat B -> flits HEAD, BODY(A), BODY(B), TAIL(C). flit_out is stable during the stall and data_ready = 0 while the slot is full.
3. dest (4,0), len 2 -> no flit_valid ever; err_dest pulses once; both beats consumed; pkts_dropped = 1; next valid request is accepted normally.
4. Three back-to-back packets of len 1 with flit_ready = 1 -> 6 flits in 6 consecutive cycles; pkt_id = 0, 1, 2.
5. Assert rst_n after the HEAD of a len-4 packet -> flit_valid = 0 and state IDLE immediately; the next request starts with pkt_id 0 and no stray BODY flits appear.
6. 17 single-flit packets -> pkt_id sequence wraps 15 -> 0; pkts_sent = 17.
